// File: rtl/enigma_key_sequencer_if.sv
// Bus bundle between the key sequencer and its neighbours.
// - key_valid/key_in/key_ready   : plaintext letter stream from the front end
// - pos0..2/chain_data           : rotor positions and letter driven into the rotor stack
// - chain_result/chain_done      : letter returned by the rotor stack and its valid flag
// - cipher_valid/cipher_out/cipher_ready : enciphered letter stream to downstream
// slave is the sequencer's view; master is the environment's view.
interface enigma_key_sequencer_if;
  logic       key_valid;
  logic [4:0] key_in;
  logic       key_ready;
  logic [4:0] pos0;
  logic [4:0] pos1;
  logic [4:0] pos2;
  logic [4:0] chain_data;
  logic [4:0] chain_result;
  logic       chain_done;
  logic       cipher_valid;
  logic [4:0] cipher_out;
  logic       cipher_ready;

  modport slave (
    input  key_valid, key_in, chain_result, chain_done, cipher_ready,
    output key_ready, pos0, pos1, pos2, chain_data, cipher_valid, cipher_out
  );

  modport master (
    output key_valid, key_in, chain_result, chain_done, cipher_ready,
    input  key_ready, pos0, pos1, pos2, chain_data, cipher_valid, cipher_out
  );
endinterface

// File: rtl/enigma_key_sequencer.sv
// Per-keystroke Enigma controller: accepts one plaintext letter, steps the
// three rotor positions (rotor 0 fast, with rotor 1 double-stepping), drives
// the letter into the rotor chain, waits for the chain's done flag and offers
// the returned letter downstream.
// Ports:
// - clk, rst          : clock (rising edge), asynchronous active-high reset
// - load_pos          : load pos_init0..2 (only honoured in IDLE)
// - pos_init0..2      : initial ring positions; values above 25 load as 0
// - err_invalid       : one-cycle pulse on illegal key/position or chain timeout
// - bus               : key stream, rotor chain and cipher stream (slave view)
module enigma_key_sequencer #(
  parameter int unsigned NOTCH0  = 16,
  parameter int unsigned NOTCH1  = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_pos,
  input  logic [4:0]                    pos_init0,
  input  logic [4:0]                    pos_init1,
  input  logic [4:0]                    pos_init2,
  output logic                          err_invalid,
  enigma_key_sequencer_if.slave         bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STEP      = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_OUTPUT    = 3'd4;

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [2:0]    state;
  logic [4:0]    pos0_q;
  logic [4:0]    pos1_q;
  logic [4:0]    pos2_q;
  logic [4:0]    chain_data_q;
  logic [4:0]    cipher_out_q;
  logic          cipher_valid_q;
  logic          err_q;
  logic [3:0]    settle_cnt;
  logic [TW-1:0] to_cnt;

  logic          carry1;
  logic          carry2;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  // Rotor 1 steps on the rotor 0 notch and also on its own notch (double-step).
  assign carry2 = (pos1_q == 5'(NOTCH1));
  assign carry1 = (pos0_q == 5'(NOTCH0)) || carry2;

  assign bus.key_ready    = (state == S_IDLE) && !load_pos && !rst;
  assign bus.pos0         = pos0_q;
  assign bus.pos1         = pos1_q;
  assign bus.pos2         = pos2_q;
  assign bus.chain_data   = chain_data_q;
  assign bus.cipher_out   = cipher_out_q;
  assign bus.cipher_valid = cipher_valid_q;
  assign err_invalid      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pos0_q         <= '0;
      pos1_q         <= '0;
      pos2_q         <= '0;
      chain_data_q   <= '0;
      cipher_out_q   <= '0;
      cipher_valid_q <= 1'b0;
      err_q          <= 1'b0;
      settle_cnt     <= '0;
      to_cnt         <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_pos) begin
            pos0_q <= clamp26(pos_init0);
            pos1_q <= clamp26(pos_init1);
            pos2_q <= clamp26(pos_init2);
            err_q  <= (pos_init0 > 5'd25) || (pos_init1 > 5'd25) || (pos_init2 > 5'd25);
          end else if (bus.key_valid) begin
            if (bus.key_in > 5'd25) begin
              err_q <= 1'b1;
            end else begin
              chain_data_q <= bus.key_in;
              state        <= S_STEP;
            end
          end
        end
        S_STEP: begin
          pos0_q <= inc26(pos0_q);
          if (carry1) pos1_q <= inc26(pos1_q);
          if (carry2) pos2_q <= inc26(pos2_q);
          to_cnt <= '0;
          if (SETTLE == 0) begin
            state <= S_WAIT_DONE;
          end else begin
            settle_cnt <= 4'(SETTLE);
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Counter is loaded with SETTLE; leaving on 1 gives exactly SETTLE cycles.
          if (settle_cnt <= 4'd1) state <= S_WAIT_DONE;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
        S_WAIT_DONE: begin
          if (bus.chain_done) begin
            cipher_out_q   <= bus.chain_result;
            cipher_valid_q <= 1'b1;
            state          <= S_OUTPUT;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (bus.cipher_ready) begin
            cipher_valid_q <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Directed bench for enigma_key_sequencer: one default-parameter instance and
// one with NOTCH0=NOTCH1=25 for the full-wrap stepping case.
module tb_enigma_key_sequencer;

  logic       clk;
  logic       rst;
  logic       load_pos;
  logic [4:0] pos_init0;
  logic [4:0] pos_init1;
  logic [4:0] pos_init2;
  logic       err_a;
  logic       err_b;

  int n_checks;
  int n_fail;

  enigma_key_sequencer_if bus_a ();
  enigma_key_sequencer_if bus_b ();

  enigma_key_sequencer dut_a (
    .clk         (clk),
    .rst         (rst),
    .load_pos    (load_pos),
    .pos_init0   (pos_init0),
    .pos_init1   (pos_init1),
    .pos_init2   (pos_init2),
    .err_invalid (err_a),
    .bus         (bus_a)
  );

  enigma_key_sequencer #(.NOTCH0(25), .NOTCH1(25)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .load_pos    (load_pos),
    .pos_init0   (pos_init0),
    .pos_init1   (pos_init1),
    .pos_init2   (pos_init2),
    .err_invalid (err_b),
    .bus         (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
    check({tag, ".pos0"}, 32'(bus_a.pos0), 32'(p0));
    check({tag, ".pos1"}, 32'(bus_a.pos1), 32'(p1));
    check({tag, ".pos2"}, 32'(bus_a.pos2), 32'(p2));
  endtask

  // Called at a negedge; returns at the negedge where cipher_valid is seen.
  task automatic wait_cipher(input string tag);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (bus_a.cipher_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, ".cipher_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at a negedge with dut_a idle; returns at a negedge after the handshake.
  task automatic do_key(input logic [4:0] k);
    bus_a.key_valid = 1'b1;
    bus_a.key_in    = k;
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    wait_cipher("do_key");
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    load_pos  = 1'b1;
    pos_init0 = a;
    pos_init1 = b;
    pos_init2 = c;
    #1 check("load.key_ready_gated", 32'(bus_a.key_ready), 32'd0);
    @(negedge clk);
    load_pos = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst       = 1'b1;
    load_pos  = 1'b0;
    pos_init0 = '0;
    pos_init1 = '0;
    pos_init2 = '0;
    bus_a.key_valid    = 1'b0;
    bus_a.key_in       = '0;
    bus_a.chain_result = 5'd7;
    bus_a.chain_done   = 1'b1;
    bus_a.cipher_ready = 1'b1;
    bus_b.key_valid    = 1'b0;
    bus_b.key_in       = '0;
    bus_b.chain_result = 5'd0;
    bus_b.chain_done   = 1'b1;
    bus_b.cipher_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.key_ready", 32'(bus_a.key_ready), 32'd0);
    check_pos("rst", 5'd0, 5'd0, 5'd0);
    check("rst.chain_data", 32'(bus_a.chain_data), 32'd0);
    check("rst.cipher_out", 32'(bus_a.cipher_out), 32'd0);
    check("rst.cipher_valid", 32'(bus_a.cipher_valid), 32'd0);
    check("rst.err", 32'(err_a), 32'd0);
    rst = 1'b0;

    // Key 0, stub result 7: cipher_valid after edge k+4
    bus_a.key_valid = 1'b1;
    bus_a.key_in    = 5'd0;
    #1 check("t1.key_ready", 32'(bus_a.key_ready), 32'd1);
    @(negedge clk);                         // edge k
    bus_a.key_valid = 1'b0;
    #1 check("t1.key_ready_busy", 32'(bus_a.key_ready), 32'd0);
    check("t1.pos0_before_step", 32'(bus_a.pos0), 32'd0);
    @(negedge clk);                         // k+1
    check_pos("t1", 5'd1, 5'd0, 5'd0);
    @(negedge clk);                         // k+2
    @(negedge clk);                         // k+3
    check("t1.cv_k3", 32'(bus_a.cipher_valid), 32'd0);
    @(negedge clk);                         // k+4
    check("t1.cv_k4", 32'(bus_a.cipher_valid), 32'd1);
    check("t1.cipher_out", 32'(bus_a.cipher_out), 32'd7);
    @(negedge clk);                         // k+5 handshake done
    check("t1.cv_after_hs", 32'(bus_a.cipher_valid), 32'd0);
    check("t1.key_ready_after_hs", 32'(bus_a.key_ready), 32'd1);

    // Double-step of rotor 1 and carry into rotor 2
    load(5'd16, 5'd3, 5'd0);
    check_pos("t2.load", 5'd16, 5'd3, 5'd0);
    check("t2.load_err", 32'(err_a), 32'd0);
    do_key(5'd5);
    check_pos("t2.k1", 5'd17, 5'd4, 5'd0);
    do_key(5'd5);
    check_pos("t2.k2", 5'd18, 5'd5, 5'd1);

    // Full wrap on the NOTCH=25 instance
    load(5'd25, 5'd25, 5'd25);
    check("t3.b_load_pos0", 32'(bus_b.pos0), 32'd25);
    bus_b.key_valid = 1'b1;
    bus_b.key_in    = 5'd1;
    #1 check("t3.b_key_ready", 32'(bus_b.key_ready), 32'd1);
    @(negedge clk);
    bus_b.key_valid = 1'b0;
    @(negedge clk);
    check("t3.b_pos0", 32'(bus_b.pos0), 32'd0);
    check("t3.b_pos1", 32'(bus_b.pos1), 32'd0);
    check("t3.b_pos2", 32'(bus_b.pos2), 32'd0);
    repeat (6) @(negedge clk);

    // Illegal key and illegal load value (dut_a still at 25,25,25)
    bus_a.key_valid = 1'b1;
    bus_a.key_in    = 5'd27;
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    check("t4.err_key", 32'(err_a), 32'd1);
    #1 check("t4.key_ready", 32'(bus_a.key_ready), 32'd1);
    check_pos("t4.unchanged", 5'd25, 5'd25, 5'd25);
    @(negedge clk);
    check("t4.err_one_cycle", 32'(err_a), 32'd0);
    check("t4.cv_none", 32'(bus_a.cipher_valid), 32'd0);
    load(5'd30, 5'd2, 5'd3);
    check_pos("t4.load", 5'd0, 5'd2, 5'd3);
    check("t4.err_load", 32'(err_a), 32'd1);
    @(negedge clk);
    check("t4.err_load_one_cycle", 32'(err_a), 32'd0);

    // Back-pressure: output held while cipher_ready is low
    bus_a.chain_result = 5'd19;
    bus_a.cipher_ready = 1'b0;
    bus_a.key_valid    = 1'b1;
    bus_a.key_in       = 5'd8;
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    wait_cipher("t5");
    bus_a.chain_result = 5'd3;
    for (int unsigned i = 0; i < 5; i++) begin
      check("t5.hold_cv", 32'(bus_a.cipher_valid), 32'd1);
      check("t5.hold_out", 32'(bus_a.cipher_out), 32'd19);
      check("t5.hold_key_ready", 32'(bus_a.key_ready), 32'd0);
      @(negedge clk);
    end
    check("t5.still_cv", 32'(bus_a.cipher_valid), 32'd1);
    bus_a.cipher_ready = 1'b1;
    @(negedge clk);
    check("t5.cv_released", 32'(bus_a.cipher_valid), 32'd0);
    check("t5.key_ready", 32'(bus_a.key_ready), 32'd1);
    check_pos("t5", 5'd1, 5'd2, 5'd3);

    // Chain timeout: WAIT_DONE entered at k+3, error on edge k+19
    bus_a.chain_done = 1'b0;
    bus_a.key_valid  = 1'b1;
    bus_a.key_in     = 5'd4;
    @(negedge clk);                         // edge k
    bus_a.key_valid = 1'b0;
    repeat (18) @(negedge clk);             // k+18
    check("t6.err_early", 32'(err_a), 32'd0);
    check("t6.key_ready_early", 32'(bus_a.key_ready), 32'd0);
    @(negedge clk);                         // k+19
    check("t6.err", 32'(err_a), 32'd1);
    check("t6.key_ready", 32'(bus_a.key_ready), 32'd1);
    check("t6.cv", 32'(bus_a.cipher_valid), 32'd0);
    check("t6.cipher_out_kept", 32'(bus_a.cipher_out), 32'd19);
    check_pos("t6", 5'd2, 5'd2, 5'd3);
    @(negedge clk);
    check("t6.err_one_cycle", 32'(err_a), 32'd0);

    // Reset during SETTLE aborts immediately
    bus_a.chain_done = 1'b1;
    bus_a.key_valid  = 1'b1;
    bus_a.key_in     = 5'd9;
    @(negedge clk);                         // edge k
    bus_a.key_valid = 1'b0;
    @(negedge clk);                         // k+1, now in SETTLE
    check("t7.chain_data", 32'(bus_a.chain_data), 32'd9);
    rst = 1'b1;
    #1;
    check_pos("t7.rst", 5'd0, 5'd0, 5'd0);
    check("t7.chain_data_rst", 32'(bus_a.chain_data), 32'd0);
    check("t7.cipher_out_rst", 32'(bus_a.cipher_out), 32'd0);
    check("t7.cv_rst", 32'(bus_a.cipher_valid), 32'd0);
    check("t7.err_rst", 32'(err_a), 32'd0);
    check("t7.key_ready_rst", 32'(bus_a.key_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t7.key_ready_after", 32'(bus_a.key_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("t7.no_cipher", 32'(bus_a.cipher_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
